regfile_np: RTL
===============

// Module: regfile_np
// PURPOSE
//  - Parametrised multi-port register file; the generalised successor of the fixed 16:1 32-bit read mux.
//  - Width, depth and read-port count are parameters.
//  - Adds a synchronous write port, write-to-read bypass, a hardwired-zero register and a registered-read mode.
//  - Sits between decode (read addresses) and writeback (write port) in the processor datapath.
// PARAMETERS
//  - WIDTH     32  data bits per register
//  - DEPTH     32  number of registers; power of two, >=2
//  - NREAD     2   number of independent read ports, 1..4
//  - READ_REG  0   0: combinational read; 1: read data registered, 1-cycle latency
//  - ZERO_REG  1   1: register 0 reads as 0 and ignores writes; 0: register 0 is ordinary
//  - AW = $clog2(DEPTH), derived localparam
// PORTS
//  - clock               in   1           single clock; all state updates on posedge
//  - ctrl_reset          in   1           synchronous, active-high reset
//  - ctrl_writeEnable    in   1           write strobe
//  - ctrl_writeRegister  in   AW          write address
//  - data_writeReg       in   WIDTH       write data
//  - ctrl_readValid      in   NREAD       per-port read request
//  - ctrl_readRegister   in   NREAD*AW    packed read addresses; port p = [p*AW +: AW]
//  - data_readReg        out  NREAD*WIDTH packed read data; port p = [p*WIDTH +: WIDTH]
//  - data_readValid      out  NREAD       per-port read-data-valid
// BEHAVIOUR
//  - Reset: when ctrl_reset=1 at posedge, all registers become 0.
//    - READ_REG=1: data_readReg<=0 and data_readValid<=0.
//    - READ_REG=0: outputs follow the cleared array.
//    - Reset has priority over a same-cycle write. The write is dropped.
//  - Write: at posedge, if ctrl_writeEnable && !ctrl_reset, the register at ctrl_writeRegister takes data_writeReg.
//    - If ZERO_REG=1 and the address is 0, the write is discarded.
//  - Read, READ_REG=0:
//    - data_readReg[p] = array[addr_p], combinationally.
//    - data_readValid[p] = ctrl_readValid[p], combinationally.
//    - Bypass: if the port reads the register being written this cycle (writeEnable=1, nonzero or ZERO_REG=0), the port shows data_writeReg in the same cycle.
//  - Read, READ_REG=1:
//    - At posedge, data_readReg[p] <= bypassed mux value; data_readValid[p] <= ctrl_readValid[p].
//    - Latency is exactly 1 cycle. Read and write on the same cycle/address returns the new data.
//    - Ports with ctrl_readValid[p]=0 hold their previous data_readReg (clock-enable) and drop valid to 0.
//  - Reading address 0 with ZERO_REG=1 always returns 0, including under bypass.
//  - All ports are independent: simultaneous reads of the same address are allowed. No stalls, no backpressure.
//  - Read addresses are always in range by construction (AW bits, DEPTH = 2^AW). No wrap handling is needed.
//  - Reset mid-stream (READ_REG=1): results in flight are discarded.
//    - Valid is 0 the cycle after reset.
//    - The first post-reset read returns 0 for any address not yet rewritten.
// STRUCTURE
//  - Shared package/header cpu_defs: default WIDTH/DEPTH, ZERO_REG_ADDR=0, packed-slice helper macros for port indexing.
//  - Sub-module mux_n (parameters N, WIDTH): N:1 read mux built as a generate tree of 2:1 stages.
//    - One mux_n instance per read port.
//  - Storage: DEPTH x WIDTH register array with per-entry write-enable decode.
//  - Bypass compare and output flops live in the top level.
// TESTING
//  1. Reset, then read all addresses on all ports -> every data_readReg = 0. With READ_REG=1, data_readValid=0 on the first cycle.
//  2. Write 0xDEADBEEF to r5; next cycle read r5 on port 0 and r5 on port 1 -> both ports show 0xDEADBEEF.
//  3. Write 0x12345678 to r0 (ZERO_REG=1), then read r0 -> 0. With ZERO_REG=0 the read -> 0x12345678.
//  4. Same-cycle write r9=0xA5A5A5A5 with port 0 reading r9:
//     - READ_REG=0 -> same-cycle 0xA5A5A5A5.
//     - READ_REG=1 -> 0xA5A5A5A5 one cycle later with valid=1.
//  5. Write r3=0x1 with ctrl_reset=1 in the same cycle, then read r3 -> 0, because reset wins.
//  6. READ_REG=1: readValid=1 at addr r7 (=0x77), then readValid=0 at addr r8 (=0x88) -> data holds 0x77 and valid falls to 0.
//     - Sweep DEPTH=16/64, WIDTH=8/64, NREAD=1/4 with a random write/read scoreboard.

Source files
------------

// File: rtl/regfile_np_pkg.sv
// Shared defaults and small helpers for the parametrised register file.
// Imported by the register file top and its read-mux sub-module.
package regfile_np_pkg;

   localparam int DEFAULT_WIDTH = 32;
   localparam int DEFAULT_DEPTH = 32;
   localparam int DEFAULT_NREAD = 2;
   localparam int ZERO_REG_ADDR = 0;

   // Low bit of field 'port' inside a packed bus of equal-width fields.
   function automatic int sliceLo(input int port, input int fieldWidth);
      return port * fieldWidth;
   endfunction

endpackage

// File: rtl/regfile_np_mux.sv
// N:1 read multiplexer built as a binary tree of 2:1 stages.
// N must be a power of two; select bit l-1 steers tree level l.
module mux_n
   import regfile_np_pkg::*;
#(
   parameter int N     = DEFAULT_DEPTH,
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [N*WIDTH-1:0]     dataIn,
   input  logic [$clog2(N)-1:0]   sel,
   output logic [WIDTH-1:0]       dataOut
);

   localparam int LEVELS = $clog2(N);

   // Level 0 holds the raw inputs; each later level halves the candidate count.
   for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
      logic [(N>>l)*WIDTH-1:0] bus;
      if (l == 0) begin : g_leaves
         assign bus = dataIn;
      end else begin : g_pairs
         for (genvar j = 0; j < (N>>l); j++) begin : g_mux2
            assign bus[sliceLo(j, WIDTH) +: WIDTH] = sel[l-1]
               ? g_lvl[l-1].bus[sliceLo(2*j+1, WIDTH) +: WIDTH]
               : g_lvl[l-1].bus[sliceLo(2*j, WIDTH) +: WIDTH];
         end
      end
   end

   assign dataOut = g_lvl[LEVELS].bus;

endmodule

// File: rtl/regfile_np.sv
// Parametrised multi-port register file with write-to-read bypass,
// optional hardwired-zero register 0 and optional registered read ports.
module regfile_np
   import regfile_np_pkg::*;
#(
   parameter int WIDTH    = DEFAULT_WIDTH,
   parameter int DEPTH    = DEFAULT_DEPTH,
   parameter int NREAD    = DEFAULT_NREAD,
   parameter int READ_REG = 0,
   parameter int ZERO_REG = 1
) (
   input  logic                          clock,
   input  logic                          ctrl_reset,
   input  logic                          ctrl_writeEnable,
   input  logic [$clog2(DEPTH)-1:0]      ctrl_writeRegister,
   input  logic [WIDTH-1:0]              data_writeReg,
   input  logic [NREAD-1:0]              ctrl_readValid,
   input  logic [NREAD*$clog2(DEPTH)-1:0] ctrl_readRegister,
   output logic [NREAD*WIDTH-1:0]        data_readReg,
   output logic [NREAD-1:0]              data_readValid
);

   localparam int AW = $clog2(DEPTH);

   logic [DEPTH*WIDTH-1:0] arrayFlat;
   logic                   writeToZero;
   logic                   writeLive;

   assign writeToZero = (ZERO_REG != 0) && (ctrl_writeRegister == AW'(ZERO_REG_ADDR));
   // A write is visible to readers only if it will actually land in the array.
   assign writeLive   = ctrl_writeEnable && !ctrl_reset && !writeToZero;

   for (genvar e = 0; e < DEPTH; e++) begin : g_entry
      logic [WIDTH-1:0] entry;
      logic             entryWrite;

      assign entryWrite = writeLive && (ctrl_writeRegister == AW'(e));

      always_ff @(posedge clock) begin
         if (ctrl_reset) begin
            entry <= '0;
         end else if (entryWrite) begin
            entry <= data_writeReg;
         end
      end

      assign arrayFlat[sliceLo(e, WIDTH) +: WIDTH] = entry;
   end

   for (genvar p = 0; p < NREAD; p++) begin : g_port
      logic [AW-1:0]    addr;
      logic [WIDTH-1:0] muxData;
      logic [WIDTH-1:0] nextData;

      assign addr = ctrl_readRegister[sliceLo(p, AW) +: AW];

      mux_n #(
         .N     (DEPTH),
         .WIDTH (WIDTH)
      ) u_mux (
         .dataIn  (arrayFlat),
         .sel     (addr),
         .dataOut (muxData)
      );

      // Zero register wins over bypass, bypass wins over stored contents.
      always_comb begin
         nextData = muxData;
         if ((ZERO_REG != 0) && (addr == AW'(ZERO_REG_ADDR))) begin
            nextData = '0;
         end else if (writeLive && (addr == ctrl_writeRegister)) begin
            nextData = data_writeReg;
         end
      end

      if (READ_REG != 0) begin : g_regd
         logic [WIDTH-1:0] dataQ;
         logic             validQ;

         // Idle ports keep their last data so downstream can hold operands.
         always_ff @(posedge clock) begin
            if (ctrl_reset) begin
               dataQ  <= '0;
               validQ <= 1'b0;
            end else begin
               validQ <= ctrl_readValid[p];
               if (ctrl_readValid[p]) begin
                  dataQ <= nextData;
               end
            end
         end

         assign data_readReg[sliceLo(p, WIDTH) +: WIDTH] = dataQ;
         assign data_readValid[p]                        = validQ;
      end else begin : g_comb
         assign data_readReg[sliceLo(p, WIDTH) +: WIDTH] = nextData;
         assign data_readValid[p]                        = ctrl_readValid[p];
      end
   end

endmodule
